// File: rtl/ttl_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ttl_out_pkg
//  Purpose  : Shared types and command-word field offsets for the multi-channel
//             TTL output sequencer.
//  Contents : mode_e      - command mode field encoding
//             ch_state_e  - per-channel sequencer state
//             *_LSB       - bit offsets of the fields inside the 128-bit command
//  Revision : 1.0 - initial release
// ============================================================================
package ttl_out_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'd0,
      MODE_PULSE  = 2'd1,
      MODE_REPEAT = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_HOLD   = 1'b0,
      ST_REPEAT = 1'b1
   } ch_state_e;

   localparam int PAT_LSB  = 0;
   localparam int CNT_LSB  = 96;
   localparam int MODE_LSB = 112;
   localparam int MASK_LSB = 120;

endpackage
`default_nettype wire

// File: rtl/ttl_channel_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ttl_channel_seq
//  Purpose  : One TTL channel of the sequencer. Tracks HOLD/REPEAT state, the
//             repeat counter, the current pattern word and the held level, and
//             produces the raw (pre-polarity) sample word for this channel.
//  Ports    : clk        in   fabric clock
//             resetn     in   synchronous active-low reset
//             i_freeze   in   hold all state (override active)
//             i_cmd_en   in   a HOLD/PULSE/REPEAT command targets this channel
//             i_mode     in   command mode
//             i_pattern  in   SER_W-sample pattern for this channel
//             i_count    in   repeat count (pattern shown count+1 cycles)
//             o_raw      out  raw sample word for this cycle
//             o_active   out  channel is in REPEAT
//  Revision : 1.0 - initial release
// ============================================================================
module ttl_channel_seq
   import ttl_out_pkg::*;
#(
   parameter int SER_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_freeze,
   input  logic             i_cmd_en,
   input  mode_e            i_mode,
   input  logic [SER_W-1:0] i_pattern,
   input  logic [CNT_W-1:0] i_count,
   output logic [SER_W-1:0] o_raw,
   output logic             o_active
);

   ch_state_e        r_state, w_state;
   logic [CNT_W-1:0] r_cnt,   w_cnt;
   logic [SER_W-1:0] r_pat,   w_pat;
   logic             r_held,  w_held;
   // In HOLD: show the pattern word for exactly one cycle before the held level.
   logic             r_show,  w_show;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_HOLD;
         r_cnt   <= '0;
         r_pat   <= '0;
         r_held  <= 1'b0;
         r_show  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_pat   <= w_pat;
         r_held  <= w_held;
         r_show  <= w_show;
      end
   end

   // Next-state logic
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_pat   = r_pat;
      w_held  = r_held;
      w_show  = r_show;
      if (!i_freeze) begin
         if (i_cmd_en) begin
            // A new command always wins, including over a running REPEAT.
            w_pat  = i_pattern;
            w_show = 1'b1;
            case (i_mode)
               MODE_PULSE: begin
                  w_state = ST_HOLD;
                  w_held  = 1'b0;
               end
               MODE_REPEAT: begin
                  w_held = i_pattern[SER_W-1];
                  if (i_count == '0) begin
                     // Zero count is a single-cycle showing, same as HOLD timing.
                     w_state = ST_HOLD;
                  end else begin
                     w_state = ST_REPEAT;
                     w_cnt   = i_count;
                     w_show  = 1'b0;
                  end
               end
               default: begin
                  w_state = ST_HOLD;
                  w_held  = i_pattern[SER_W-1];
               end
            endcase
         end else begin
            case (r_state)
               ST_REPEAT: begin
                  // The last pattern cycle is spent in HOLD with r_show set, so
                  // ch_active drops for the final repetition.
                  if (r_cnt == CNT_W'(1)) begin
                     w_state = ST_HOLD;
                     w_show  = 1'b1;
                  end else begin
                     w_cnt = r_cnt - CNT_W'(1);
                  end
               end
               default: begin
                  w_show = 1'b0;
               end
            endcase
         end
      end
   end

   // Output logic
   always_comb begin
      o_active = (r_state == ST_REPEAT);
      if ((r_state == ST_REPEAT) || r_show) begin
         o_raw = r_pat;
      end else begin
         o_raw = {SER_W{r_held}};
      end
   end

endmodule
`default_nettype wire

// File: rtl/ttl_multi_out_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ttl_multi_out_sequencer
//  Purpose  : Multi-channel TTL output sequencer between GPO_Core and per-pin
//             serializers. Decodes the command word, runs one ttl_channel_seq
//             per channel, aggregates errors, applies override and polarity and
//             registers the serializer words (LSB = first sample in time).
//  Ports    : clk             in   fabric clock (serializer CLKDIV)
//             resetn          in   synchronous active-low reset
//             cmd_valid       in   command strobe
//             cmd_data        in   128-bit command word
//             override_en     in   force all channels to override levels
//             override_value  in   per-channel static override level
//             ser_data        out  serializer words, ch c = [c*SER_W +: SER_W]
//             ch_active       out  channel in REPEAT
//             preempt_err     out  pulse: command hit a channel in REPEAT
//             mode_err        out  pulse: reserved mode received
//             overridden      out  pulse: command dropped due to override
//  Revision : 1.0 - initial release
// ============================================================================
module ttl_multi_out_sequencer
   import ttl_out_pkg::*;
#(
   parameter int         N_CH     = 8,
   parameter int         SER_W    = 8,
   parameter int         CNT_W    = 16,
   parameter logic [7:0] INV_MASK = 8'h00
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cmd_valid,
   input  logic [127:0]          cmd_data,
   input  logic                  override_en,
   input  logic [N_CH-1:0]       override_value,
   output logic [N_CH*SER_W-1:0] ser_data,
   output logic [N_CH-1:0]       ch_active,
   output logic                  preempt_err,
   output logic                  mode_err,
   output logic                  overridden
);

   // ---------------- field decode ----------------
   logic [N_CH*SER_W-1:0] w_pattern;
   logic [CNT_W-1:0]      w_count;
   mode_e                 w_mode;
   logic [N_CH-1:0]       w_mask;
   logic                  w_unused_cmd;

   assign w_pattern    = cmd_data[PAT_LSB +: N_CH*SER_W];
   assign w_count      = cmd_data[CNT_LSB +: CNT_W];
   assign w_mode       = mode_e'(cmd_data[MODE_LSB +: 2]);
   assign w_mask       = cmd_data[MASK_LSB +: N_CH];
   assign w_unused_cmd = ^cmd_data;

   // Override takes priority over any command in the same cycle.
   logic w_cmd_ok;
   logic w_mode_err;
   logic w_drop;
   logic w_preempt;

   assign w_cmd_ok   = cmd_valid && !override_en && (w_mode != MODE_RSVD);
   assign w_mode_err = cmd_valid && !override_en && (w_mode == MODE_RSVD);
   assign w_drop     = cmd_valid && override_en;

   // ---------------- channels ----------------
   logic [N_CH*SER_W-1:0] w_raw_word;
   logic [N_CH*SER_W-1:0] w_inv_word;
   logic [N_CH*SER_W-1:0] w_ovr_word;
   logic [N_CH-1:0]       w_active;
   logic [N_CH-1:0]       r_ovr_val;

   genvar c;
   generate
      for (c = 0; c < N_CH; c++) begin : g_ch
         ttl_channel_seq #(
            .SER_W (SER_W),
            .CNT_W (CNT_W)
         ) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .i_freeze  (override_en),
            .i_cmd_en  (w_cmd_ok && w_mask[c]),
            .i_mode    (w_mode),
            .i_pattern (w_pattern[c*SER_W +: SER_W]),
            .i_count   (w_count),
            .o_raw     (w_raw_word[c*SER_W +: SER_W]),
            .o_active  (w_active[c])
         );
         assign w_inv_word[c*SER_W +: SER_W] = {SER_W{INV_MASK[c]}};
         assign w_ovr_word[c*SER_W +: SER_W] = {SER_W{r_ovr_val[c]}};
      end
   endgenerate

   assign w_preempt = w_cmd_ok && ((w_mask & w_active) != '0);

   // ---------------- pipeline ----------------
   // Command-side flags and the override select are staged once so that they
   // line up with the channel words, which already sit one register deep.
   logic                  r_pre_s1;
   logic                  r_mode_s1;
   logic                  r_drop_s1;
   logic                  r_ovr_s1;
   logic [N_CH*SER_W-1:0] r_ser_data;
   logic [N_CH-1:0]       r_ch_active;
   logic                  r_preempt_err;
   logic                  r_mode_err;
   logic                  r_overridden;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pre_s1      <= 1'b0;
         r_mode_s1     <= 1'b0;
         r_drop_s1     <= 1'b0;
         r_ovr_s1      <= 1'b0;
         r_ovr_val     <= '0;
         r_ser_data    <= w_inv_word;
         r_ch_active   <= '0;
         r_preempt_err <= 1'b0;
         r_mode_err    <= 1'b0;
         r_overridden  <= 1'b0;
      end else begin
         r_pre_s1      <= w_preempt;
         r_mode_s1     <= w_mode_err;
         r_drop_s1     <= w_drop;
         r_ovr_s1      <= override_en;
         r_ovr_val     <= override_value;
         r_ser_data    <= (r_ovr_s1 ? w_ovr_word : w_raw_word) ^ w_inv_word;
         r_ch_active   <= w_active;
         r_preempt_err <= r_pre_s1;
         r_mode_err    <= r_mode_s1;
         r_overridden  <= r_drop_s1;
      end
   end

   assign ser_data    = r_ser_data;
   assign ch_active   = r_ch_active;
   assign preempt_err = r_preempt_err;
   assign mode_err    = r_mode_err;
   assign overridden  = r_overridden;

endmodule
`default_nettype wire

// File: tb/tb_ttl_multi_out_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ttl_multi_out_sequencer
//  Purpose  : Self-checking bench for ttl_multi_out_sequencer. Each driven cycle
//             pushes the expected outputs from a schedule-based reference model
//             into a scoreboard; a monitor pops and compares after each edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ttl_multi_out_sequencer;

   localparam logic [7:0] INV = 8'h05;

   logic          clk;
   logic          resetn;
   logic          cmd_valid;
   logic [127:0]  cmd_data;
   logic          override_en;
   logic [7:0]    override_value;
   logic [63:0]   ser_data;
   logic [7:0]    ch_active;
   logic          preempt_err;
   logic          mode_err;
   logic          overridden;

   ttl_multi_out_sequencer #(
      .N_CH     (8),
      .SER_W    (8),
      .CNT_W    (16),
      .INV_MASK (INV)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .cmd_valid      (cmd_valid),
      .cmd_data       (cmd_data),
      .override_en    (override_en),
      .override_value (override_value),
      .ser_data       (ser_data),
      .ch_active      (ch_active),
      .preempt_err    (preempt_err),
      .mode_err       (mode_err),
      .overridden     (overridden)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] ser;
      logic [7:0]  act;
      logic        pre;
      logic        me;
      logic        ov;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // ---------------- reference model ----------------
   // Each channel owns a schedule: rem pattern words still to be shown, then
   // the held level forever. A word is "active" when more pattern words follow.
   int         m_rem[8];
   logic [7:0] m_pat[8];
   logic       m_held[8];
   logic       m_prev_ovr = 1'b0;
   logic [7:0] m_prev_ovv = 8'h00;
   logic       m_pend_pre = 1'b0;
   logic       m_pend_me  = 1'b0;
   logic       m_pend_drop = 1'b0;

   task automatic step(input logic v, input logic [127:0] d, input logic ov,
                       input logic [7:0] ovv, input logic rn);
      exp_t       e;
      logic [1:0] md;
      logic [7:0] mk;
      logic [7:0] w;
      int         cnt;
      logic       cur_act[8];
      @(negedge clk);
      cmd_valid      = v;
      cmd_data       = d;
      override_en    = ov;
      override_value = ovv;
      resetn         = rn;
      e = '0;
      if (!rn) begin
         for (int c = 0; c < 8; c++) begin
            m_rem[c]  = 0;
            m_pat[c]  = 8'h00;
            m_held[c] = 1'b0;
            e.ser[c*8 +: 8] = {8{INV[c]}};
         end
         m_prev_ovr  = 1'b0;
         m_prev_ovv  = 8'h00;
         m_pend_pre  = 1'b0;
         m_pend_me   = 1'b0;
         m_pend_drop = 1'b0;
      end else begin
         for (int c = 0; c < 8; c++) begin
            if (m_prev_ovr)      w = {8{m_prev_ovv[c]}};
            else if (m_rem[c] > 0) w = m_pat[c];
            else                 w = {8{m_held[c]}};
            e.ser[c*8 +: 8] = w ^ {8{INV[c]}};
            cur_act[c] = (m_rem[c] > 1);
            e.act[c]   = cur_act[c];
         end
         e.pre = m_pend_pre;
         e.me  = m_pend_me;
         e.ov  = m_pend_drop;
         m_pend_pre  = 1'b0;
         m_pend_me   = 1'b0;
         m_pend_drop = 1'b0;
         if (ov) begin
            m_pend_drop = v;
         end else begin
            for (int c = 0; c < 8; c++)
               if (m_rem[c] > 0) m_rem[c] = m_rem[c] - 1;
            if (v) begin
               md  = d[113:112];
               mk  = d[127:120];
               cnt = int'(d[111:96]);
               if (md == 2'd3) begin
                  m_pend_me = 1'b1;
               end else begin
                  for (int c = 0; c < 8; c++) begin
                     if (mk[c]) begin
                        if (cur_act[c]) m_pend_pre = 1'b1;
                        m_pat[c] = d[c*8 +: 8];
                        if (md == 2'd0) begin
                           m_rem[c] = 1; m_held[c] = m_pat[c][7];
                        end else if (md == 2'd1) begin
                           m_rem[c] = 1; m_held[c] = 1'b0;
                        end else begin
                           m_rem[c] = cnt + 1; m_held[c] = m_pat[c][7];
                        end
                     end
                  end
               end
            end
         end
         m_prev_ovr = ov;
         m_prev_ovv = ovv;
      end
      sb.push_back(e);
   endtask

   function automatic logic [127:0] mk_cmd(input logic [1:0] md, input logic [7:0] mk,
                                           input logic [15:0] cnt, input logic [63:0] pat);
      logic [127:0] r;
      r = '0;
      r[63:0]    = pat;
      r[111:96]  = cnt;
      r[113:112] = md;
      r[127:120] = mk;
      return r;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic cmd(input logic [127:0] d);
      step(1'b1, d, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ser_data",    ser_data,               e.ser);
            chk("ch_active",   64'(ch_active),         64'(e.act));
            chk("preempt_err", 64'(preempt_err),       64'(e.pre));
            chk("mode_err",    64'(mode_err),          64'(e.me));
            chk("overridden",  64'(overridden),        64'(e.ov));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [127:0] rd;
   logic         rv;
   logic         rov;
   logic         rrn;

   initial begin
      resetn         = 1'b0;
      cmd_valid      = 1'b0;
      cmd_data       = '0;
      override_en    = 1'b0;
      override_value = 8'h00;

      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 8'h00, 1'b0);
      idle(2);

      // HOLD on ch0: low MSB then high MSB
      cmd(mk_cmd(2'd0, 8'h01, 16'd0, 64'h0F));
      idle(3);
      cmd(mk_cmd(2'd0, 8'h01, 16'd0, 64'hF0));
      idle(3);

      // REPEAT on ch3, then PULSE
      cmd(mk_cmd(2'd2, 8'h08, 16'd3, 64'hA5 << 24));
      idle(6);
      cmd(mk_cmd(2'd1, 8'h08, 16'd0, 64'h81 << 24));
      idle(3);

      // REPEAT count 0 boundary
      cmd(mk_cmd(2'd2, 8'h10, 16'd0, 64'hC3 << 32));
      idle(3);

      // Preempt a long REPEAT on ch1
      cmd(mk_cmd(2'd2, 8'h02, 16'd10, 64'h5A << 8));
      idle(3);
      cmd(mk_cmd(2'd0, 8'h02, 16'd0, 64'h00));
      idle(3);

      // Override during REPEAT, with a simultaneous command that must be dropped
      cmd(mk_cmd(2'd2, 8'h02, 16'd5, 64'h3C << 8));
      idle(1);
      step(1'b1, mk_cmd(2'd0, 8'hFF, 16'd0, 64'hFFFF_FFFF_FFFF_FFFF), 1'b1, 8'h02, 1'b1);
      step(1'b0, '0, 1'b1, 8'h02, 1'b1);
      step(1'b0, '0, 1'b1, 8'h02, 1'b1);
      idle(8);

      // Reserved mode
      cmd(mk_cmd(2'd3, 8'hFF, 16'd2, 64'hDEAD_BEEF_0123_4567));
      idle(2);

      // Reset mid-REPEAT
      cmd(mk_cmd(2'd2, 8'h04, 16'd8, 64'h99 << 16));
      idle(2);
      step(1'b0, '0, 1'b0, 8'h00, 1'b0);
      idle(3);

      // Randomized traffic, including garbage in unused command bits
      for (int i = 0; i < 3000; i++) begin
         rd = {$urandom(), $urandom(), $urandom(), $urandom()};
         rd[111:96] = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 3) != 0) rd[113:112] = 2'($urandom_range(0, 2));
         rv  = ($urandom_range(0, 9) < 4);
         rov = ($urandom_range(0, 19) == 0);
         rrn = ($urandom_range(0, 299) != 0);
         step(rv, rd, rov, 8'($urandom()), rrn);
      end
      idle(2);

      @(posedge clk);
      #2;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
